// File: rtl/icache_req_arb_aged_pkg.sv
// Shared icache request types and defaults used by the request arbiter and its bench.
package toy_pack;

  localparam int ICACHE_ARB_NUM_CH = 3;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  tid;
  } pc_req_t;

  // Source-index width; a single channel still needs one bit.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_req_arb_aged_if.sv
// Arbiter bus: per-channel request handshake in, single tag request out.
interface icache_req_arb_aged_if
  import toy_pack::*;
#(
  parameter int NUM_CH = ICACHE_ARB_NUM_CH
);
  localparam int SRC_W = src_w(NUM_CH);

  logic [NUM_CH-1:0]   v_req_vld;
  logic [NUM_CH-1:0]   v_req_rdy;
  pc_req_t [NUM_CH-1:0] v_req_pld;
  logic                tagram_req_rdy;
  logic                mshr_tag_req_rdy;
  logic                tag_req_vld;
  pc_req_t             tag_req_pld;
  logic [SRC_W-1:0]    tag_req_src;

  modport slave (
    input  v_req_vld, v_req_pld, tagram_req_rdy, mshr_tag_req_rdy,
    output v_req_rdy, tag_req_vld, tag_req_pld, tag_req_src
  );

  modport master (
    output v_req_vld, v_req_pld, tagram_req_rdy, mshr_tag_req_rdy,
    input  v_req_rdy, tag_req_vld, tag_req_pld, tag_req_src
  );

endinterface

// File: rtl/icache_req_arb_aged_age_cnt.sv
// Per-channel starvation counter: ages only on cycles where another channel wins.
module icache_arb_age_cnt #(
  parameter int STARVE_TH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_vld,
  input  logic req_won,
  input  logic any_acc,
  output logic promoted
);
  localparam int CW = $clog2(STARVE_TH + 1);
  localparam logic [CW-1:0] TH = CW'(STARVE_TH);

  logic [CW-1:0] cnt;

  // A withdrawn request forgets its age even on stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (!req_vld || req_won) cnt <= '0;
    else if (any_acc && cnt != TH) cnt <= cnt + CW'(1);
  end

  assign promoted = (cnt == TH);

endmodule

// File: rtl/icache_req_arb_aged.sv
// Fixed-priority icache request arbiter with optional starvation aging and a
// one-entry registered output. Aging is built only when ICACHE_REQ_ARB_AGING_EN is defined.
module icache_req_arb_aged
  import toy_pack::*;
#(
  parameter int NUM_CH    = ICACHE_ARB_NUM_CH,
  parameter int STARVE_TH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  icache_req_arb_aged_if.slave bus
);
  localparam int SRC_W = src_w(NUM_CH);

  logic              ds_rdy, xfer_out, can_accept, accept, gnt_any;
  logic [SRC_W-1:0]  gnt_idx;
  logic [NUM_CH-1:0] promoted, gnt_oh, won;

  if (STARVE_TH < 1) begin : g_th_bad
    $error("STARVE_TH must be at least 1");
  end

  assign ds_rdy     = bus.tagram_req_rdy & bus.mshr_tag_req_rdy;
  assign xfer_out   = bus.tag_req_vld & ds_rdy;
  assign can_accept = ~bus.tag_req_vld | xfer_out;

  // Lowest valid wins; a lowest promoted valid channel overrides it.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.v_req_vld[i]) begin
        gnt_any = 1'b1;
        gnt_idx = SRC_W'(i);
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.v_req_vld[i] && promoted[i]) gnt_idx = SRC_W'(i);
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < NUM_CH; i++) gnt_oh[i] = gnt_any && (gnt_idx == SRC_W'(i));
  end

  // Ready is held low while reset is asserted, even though the register reads empty.
  assign bus.v_req_rdy = gnt_oh & {NUM_CH{can_accept & rst_n}};
  assign won           = bus.v_req_rdy & bus.v_req_vld;
  assign accept        = |won;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.tag_req_vld <= 1'b0;
      bus.tag_req_pld <= '0;
      bus.tag_req_src <= '0;
    end else if (accept) begin
      bus.tag_req_vld <= 1'b1;
      bus.tag_req_pld <= bus.v_req_pld[gnt_idx];
      bus.tag_req_src <= gnt_idx;
    end else if (xfer_out) begin
      bus.tag_req_vld <= 1'b0;
    end
  end

`ifdef ICACHE_REQ_ARB_AGING_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_age
    icache_arb_age_cnt #(.STARVE_TH(STARVE_TH)) u_age (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_vld  (bus.v_req_vld[i]),
      .req_won  (won[i]),
      .any_acc  (accept),
      .promoted (promoted[i])
    );
  end
`else
  assign promoted = '0;
`endif

endmodule

// File: tb/tb_icache_req_arb_aged.sv
// Scoreboard bench for icache_req_arb_aged: directed starvation/backpressure/reset cases plus random traffic.
module tb_icache_req_arb_aged;
  import toy_pack::*;

  localparam int NCH = 3;
  localparam int TH  = 4;
`ifdef ICACHE_REQ_ARB_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  typedef struct packed {
    pc_req_t    pld;
    logic [1:0] src;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  bit   in_rst = 1'b0;
  exp_t sb_q[$];
  int   age[NCH];

  icache_req_arb_aged_if #(.NUM_CH(NCH)) bus();

  icache_req_arb_aged #(.NUM_CH(NCH), .STARVE_TH(TH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk_i(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_v(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: output valid must track the expected one-entry occupancy; each transfer pops one entry.
  always @(negedge clk) begin : mon
    bit   ds, ev;
    exp_t e;
    if (mon_en) begin
      ds = bus.tagram_req_rdy & bus.mshr_tag_req_rdy;
      ev = (sb_q.size() != 0);
      chk_i("tag_req_vld", int'(bus.tag_req_vld), int'(ev));
      if (ev && ds) begin
        e = sb_q.pop_front();
        if (bus.tag_req_vld) begin
          chk_v("tag_req_pld", 64'(bus.tag_req_pld), 64'(e.pld));
          chk_i("tag_req_src", int'(bus.tag_req_src), int'(e.src));
        end
      end
    end
  end

  // Reference: grant from the priority rules, then age every waiting channel that lost.
  task automatic step(output int g);
    logic [NCH-1:0] v = bus.v_req_vld;
    bit can = !in_rst && (sb_q.size() == 0);
    g = -1;
    if (can) begin
      for (int i = 0; i < NCH; i++) if (g < 0 && v[i] && AGING && age[i] >= TH) g = i;
      for (int i = 0; i < NCH; i++) if (g < 0 && v[i]) g = i;
    end
    chk_i("v_req_rdy", int'(bus.v_req_rdy), (g < 0) ? 0 : (1 << g));
    if (g >= 0) sb_q.push_back('{pld: bus.v_req_pld[g], src: 2'(g)});
    for (int i = 0; i < NCH; i++) begin
      if (!v[i] || i == g)         age[i] = 0;
      else if (g >= 0 && age[i] < TH) age[i] = age[i] + 1;
    end
  endtask

  task automatic cyc(input logic [NCH-1:0] v, input bit tr, input bit mr, output int g);
    @(posedge clk); #1;
    bus.v_req_vld = v;
    for (int i = 0; i < NCH; i++) bus.v_req_pld[i] = '{addr: $urandom, tid: 4'($urandom)};
    bus.tagram_req_rdy   = tr;
    bus.mshr_tag_req_rdy = mr;
    @(negedge clk); #1;
    step(g);
  endtask

  task automatic idle(input int n);
    int g;
    repeat (n) cyc('0, 1'b1, 1'b1, g);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n  = 1'b0;
    in_rst = 1'b1;
    sb_q.delete();
    foreach (age[i]) age[i] = 0;
    repeat (n) begin
      @(negedge clk); #1;
      chk_i("rst_vld", int'(bus.tag_req_vld), 0);
      chk_v("rst_pld", 64'(bus.tag_req_pld), 64'd0);
      chk_i("rst_src", int'(bus.tag_req_src), 0);
      chk_i("rst_rdy", int'(bus.v_req_rdy), 0);
    end
    bus.v_req_vld = '0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    in_rst = 1'b0;
  endtask

  initial begin
    int g, k, n;
    bus.v_req_vld        = '0;
    bus.v_req_pld        = '0;
    bus.tagram_req_rdy   = 1'b0;
    bus.mshr_tag_req_rdy = 1'b0;
    bus.v_req_vld        = 3'b111;  // requests pending during reset must see no ready
    do_reset(2);
    mon_en = 1'b1;

    // All three channels together: ch0 first, then one grant per cycle.
    cyc(3'b111, 1'b1, 1'b1, g);
    chk_i("a_first_gnt", g, 0);
    n = 1;
    cyc(3'b111, 1'b1, 1'b1, g);
    chk_i("a_vld_c1", int'(bus.tag_req_vld), 1);
    chk_i("a_src_c1", int'(bus.tag_req_src), 0);
    if (g >= 0) n++;
    repeat (2) begin
      cyc(3'b111, 1'b1, 1'b1, g);
      if (g >= 0) n++;
    end
    chk_i("a_pipelined", n, 4);
    idle(2);

    // ch0 hogs, ch2 waits: promoted on the 5th accept cycle only when aging.
    k = -1;
    for (int c = 0; c < 20; c++) begin
      cyc(3'b101, 1'b1, 1'b1, g);
      if (g == 2 && k < 0) k = c;
    end
    chk_i("b_ch2_first", k, AGING ? 4 : -1);
    idle(2);

    // Backpressure from MSHR alone: output frozen, no grants, ch2 age frozen at 3.
    cyc(3'b101, 1'b1, 1'b1, g);
    cyc(3'b101, 1'b1, 1'b1, g);
    cyc(3'b110, 1'b1, 1'b1, g);
    chk_i("c_ch1_gnt", g, 1);
    repeat (6) begin
      cyc(3'b100, 1'b1, 1'b0, g);
      chk_i("c_stall_rdy", int'(bus.v_req_rdy), 0);
      chk_i("c_stall_src", int'(bus.tag_req_src), 1);
    end
    cyc(3'b101, 1'b1, 1'b1, g);
    chk_i("c_after_stall", g, 0);
    cyc(3'b101, 1'b1, 1'b1, g);
    chk_i("c_promote", g, AGING ? 2 : 0);
    idle(2);

    // Drain and refill in the same cycle.
    cyc(3'b001, 1'b1, 1'b1, g);
    cyc(3'b010, 1'b1, 1'b1, g);
    chk_i("d_refill_gnt", g, 1);
    chk_i("d_src_before", int'(bus.tag_req_src), 0);
    cyc(3'b000, 1'b1, 1'b1, g);
    chk_i("d_vld_kept", int'(bus.tag_req_vld), 1);
    chk_i("d_src_after", int'(bus.tag_req_src), 1);
    idle(2);

    // Reset mid-transfer with ch2 aged to 3, then fixed priority afresh.
    repeat (3) cyc(3'b101, 1'b1, 1'b1, g);
    cyc(3'b101, 1'b0, 1'b0, g);
    do_reset(2);
    cyc(3'b101, 1'b1, 1'b1, g);
    chk_i("e_post_rst_gnt", g, 0);
    cyc(3'b101, 1'b1, 1'b1, g);
    chk_i("e_age_cleared", g, 0);
    idle(2);

    // Random traffic against the reference.
    for (int c = 0; c < 400; c++)
      cyc(3'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, g);

    idle(3);
    chk_i("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
